// File: rtl/rr_arbiter_4_if.sv
// Handshake bundle between requesters and the rr_arbiter_4 round-robin arbiter.
// The master side drives the requests and the completion strobe. The slave
// side (the arbiter) returns the one-hot grant, the grant-valid flag and the
// forced-release pulse.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       en;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  en,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output en,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a registered one-hot
// grant and a grant-valid strobe. It feeds a 4-to-2 encoder: grant is the
// one-hot code and en is the encoder enable.
// A rotating pointer gives priority to the requester after the last winner.
// A grant is held until the owner asserts done or drops its request.
// Optional feature: define RR_ARB_TIMEOUT_EN to force a release after the
// grant has been held for MAX_HOLD cycles. The forced release pulses timeout.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter_4_if.slave bus
);

  // Reject an out-of-range hold limit at elaboration instead of wrapping it silently.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;        // highest-priority requester for the next arbitration
  logic [1:0] owner;      // index of the current grant holder
  logic [3:0] grant_q;
  logic       en_q;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       release_req;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;   // GRANT cycles elapsed since the grant edge
  logic       timeout_q;
  logic       hold_limit;

  // The grant edge counts as the first held cycle, so the limit is reached at MAX_HOLD-1.
  assign hold_limit  = (hold_cnt == 8'(MAX_HOLD - 1));
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  // Rotating priority search: the first set request at offset 0..3 from ptr wins.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    // Walk downward so the smallest offset from ptr is the final assignment.
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[ptr + 2'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr + 2'(i);
      end
    end
  end

  // A normal release happens when the owner finishes or withdraws its request.
  // If both happen in the same cycle, they count as a single release.
  assign release_req = bus.done || !bus.req[owner];

  // Two-state arbitration FSM with registered grant/en/timeout outputs.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, and no ordering race occurs between blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      owner   <= 2'd0;
      grant_q <= 4'b0000;
      en_q    <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_q <= 4'b0001 << pick_idx;
            en_q    <= 1'b1;
            owner   <= pick_idx;
            state   <= GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (release_req) begin
            grant_q <= 4'b0000;
            en_q    <= 1'b0;
            ptr     <= owner + 2'd1;
            state   <= IDLE;
`ifdef RR_ARB_TIMEOUT_EN
          end else if (hold_limit) begin
            grant_q   <= 4'b0000;
            en_q      <= 1'b0;
            ptr       <= owner + 2'd1;
            state     <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.en    = en_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4.
// It runs a fixed vector table with hand-derived expected outputs, a long-hold
// sequence and a random phase. A behavioural reference model predicts the
// outputs of every cycle. Each prediction goes into a scoreboard queue when the
// stimulus is driven, and is popped and compared one edge later.
module tb_rr_arbiter_4;
  localparam int unsigned HOLD = 4;

  logic clk = 1'b0;
  logic rst;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic       en;
    logic       timeout;
  } out_t;

  typedef struct {
    logic       r;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       en;
    logic       to;
  } vec_t;

  out_t sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] prev_grant = 4'b0000;

  // Reference model state.
  logic       m_busy;
  logic [1:0] m_ptr;
  logic [1:0] m_owner;
  logic [3:0] m_grant;
  logic       m_en;
  logic       m_to;
  int         m_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The model's view of one rising edge.
  task automatic model_edge(input logic r, input logic [3:0] rq, input logic d);
    int idx;
    if (r) begin
      m_busy = 1'b0; m_ptr = 2'd0; m_owner = 2'd0;
      m_grant = 4'b0; m_en = 1'b0; m_to = 1'b0; m_held = 0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          idx = (int'(m_ptr) + k) % 4;
          if (rq[idx]) begin
            m_busy = 1'b1; m_owner = 2'(idx);
            m_grant = 4'b0; m_grant[idx] = 1'b1; m_en = 1'b1; m_held = 1;
            break;
          end
        end
      end else if (d || !rq[m_owner]) begin
        m_busy = 1'b0; m_grant = 4'b0; m_en = 1'b0; m_ptr = m_owner + 2'd1;
      end
`ifdef RR_ARB_TIMEOUT_EN
      else if (m_held == int'(HOLD)) begin
        m_busy = 1'b0; m_grant = 4'b0; m_en = 1'b0; m_ptr = m_owner + 2'd1; m_to = 1'b1;
      end
`endif
      else begin
        m_held++;
      end
    end
  endtask

  // Drive one cycle and scoreboard the DUT outputs against the model.
  task automatic step(input logic r, input logic [3:0] rq, input logic d, output out_t got);
    out_t exp;
    @(negedge clk);
    rst = r; bus.req = rq; bus.done = d;
    model_edge(r, rq, d);
    sb_q.push_back('{grant: m_grant, en: m_en, timeout: m_to});
    @(posedge clk);
    #1;
    got = '{grant: bus.grant, en: bus.en, timeout: bus.timeout};
    exp = sb_q.pop_front();
    check("scoreboard", 32'(got), 32'(exp));
    check("grant_onehot0", 32'($onehot0(got.grant)), 32'd1);
    check("en_matches_grant", 32'(got.en), 32'(|got.grant));
    check("no_direct_switch",
          32'((prev_grant != 4'b0) && (got.grant != 4'b0) && (got.grant != prev_grant)), 32'd0);
    prev_grant = got.grant;
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic [3:0] g, input logic e, input logic t);
    vecs.push_back('{r: r, req: rq, done: d, grant: g, en: e, to: t});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    out_t got;
    int   en_cnt;
    int   to_cnt;

    rst = 1'b1; bus.req = 4'b0; bus.done = 1'b0;

    // Reset held with all requests active; first grant afterwards goes to 0.
    add(1, 4'hF, 0, 4'b0000, 0, 0);
    add(1, 4'hF, 0, 4'b0000, 0, 0);
    add(0, 4'hF, 0, 4'b0001, 1, 0);
    add(0, 4'hF, 1, 4'b0000, 0, 0);
    // Rotation with all requesting: 0010, 0100, 1000, wrap to 0001.
    add(0, 4'hF, 0, 4'b0010, 1, 0);
    add(0, 4'hF, 1, 4'b0000, 0, 0);
    add(0, 4'hF, 0, 4'b0100, 1, 0);
    add(0, 4'hF, 1, 4'b0000, 0, 0);
    add(0, 4'hF, 0, 4'b1000, 1, 0);
    add(0, 4'hF, 1, 4'b0000, 0, 0);
    add(0, 4'hF, 0, 4'b0001, 1, 0);
    add(0, 4'hF, 1, 4'b0000, 0, 0);
    // Single requester 2: three grant cycles, release on done, then ptr = 3.
    add(0, 4'h4, 0, 4'b0100, 1, 0);
    add(0, 4'h4, 0, 4'b0100, 1, 0);
    add(0, 4'h4, 0, 4'b0100, 1, 0);
    add(0, 4'h4, 1, 4'b0000, 0, 0);
    add(0, 4'hF, 0, 4'b1000, 1, 0);
    add(0, 4'hF, 1, 4'b0000, 0, 0);
    // Owner 1 with noise on req[0] and req[3], then the owner drops its request.
    // The drop coincides with the hold limit; the release must be normal.
    add(0, 4'h2, 0, 4'b0010, 1, 0);
    add(0, 4'h3, 0, 4'b0010, 1, 0);
    add(0, 4'hA, 0, 4'b0010, 1, 0);
    add(0, 4'hB, 0, 4'b0010, 1, 0);
    add(0, 4'h9, 0, 4'b0000, 0, 0);
    add(0, 4'h9, 0, 4'b1000, 1, 0);
    add(0, 4'h9, 1, 4'b0000, 0, 0);
    // Reset mid-grant clears ptr; 1001 then goes to requester 0.
    add(0, 4'h8, 0, 4'b1000, 1, 0);
    add(1, 4'h8, 0, 4'b0000, 0, 0);
    add(0, 4'h9, 0, 4'b0001, 1, 0);
    add(0, 4'h9, 1, 4'b0000, 0, 0);
    // done in IDLE is ignored; done together with a req drop is one release.
    add(0, 4'h0, 1, 4'b0000, 0, 0);
    add(0, 4'h0, 0, 4'b0000, 0, 0);
    add(0, 4'h1, 0, 4'b0001, 1, 0);
    add(0, 4'h0, 1, 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].req, vecs[i].done, got);
      check($sformatf("vec%0d", i), 32'(got),
            32'({vecs[i].grant, vecs[i].en, vecs[i].to}));
    end

    // Long hold: req 0001 for 100 cycles with done low.
    en_cnt = 0; to_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 4'b0001, 1'b0, got);
      en_cnt += int'(got.en);
      to_cnt += int'(got.timeout);
    end
`ifdef RR_ARB_TIMEOUT_EN
    check("long_hold_en_cycles", 32'(en_cnt), 32'd80);
    check("long_hold_timeouts", 32'(to_cnt), 32'd20);
`else
    check("long_hold_en_cycles", 32'(en_cnt), 32'd100);
    check("long_hold_timeouts", 32'(to_cnt), 32'd0);
`endif

    // Random traffic, with an occasional reset.
    for (int c = 0; c < 300; c++) begin
      step(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), got);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that turns competing request lines into a registered one-hot grant plus a grant-valid strobe. It sits directly upstream of the 4-to-2 encoder: `grant[3:0]` drives the encoder's one-hot input and `en` drives its enable, so the encoder always sees a legal one-hot code or is disabled. Fairness comes from a rotating priority pointer; a grant is held until the owner signals completion.

## Interface
Parameters:
- `MAX_HOLD`, default 15: maximum number of cycles a grant may be held. Legal range 1..255. Used only when `RR_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request lines; bit i = requester i wants the resource.
- `done`  input  1  current owner has finished; sampled only while a grant is active.
- `grant`  output  4  registered grant, one-hot or all-zero.
- `en`  output  1  registered grant-valid; 1 exactly when `grant` != 0.
- `timeout`  output  1  one-cycle pulse on a forced release; constant 0 without the macro.

## Operation
- Two-state FSM: IDLE and GRANT. Internal 2-bit priority pointer `ptr` names the highest-priority requester.
- Reset, applied on a rising edge with `rst`=1 and overriding everything else:
  - state = IDLE;
  - `grant` = 4'b0000, `en` = 0, `timeout` = 0;
  - `ptr` = 0, hold counter = 0.
- IDLE:
  - If `req` == 0, stay in IDLE.
  - Otherwise select the first set bit of `req`, searching `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - Register that bit into `grant`, set `en`=1, move to GRANT.
  - `done` is ignored in IDLE.
- GRANT:
  - Hold `grant` and `en` unchanged while the winner's `req` bit is 1 and `done` is 0.
  - Release when `done` is 1 or the winner's `req` bit is 0:
    - next edge: `grant` = 0, `en` = 0, state = IDLE;
    - `ptr` = winner index + 1 (mod 4; index 3 wraps to 0).
  - Requests from non-owners never affect the current grant.
- Simultaneous events:
  - `done` together with a drop of the winner's `req` is a single release.
  - `rst` together with any release is a reset.
- Invariants, at every cycle:
  - `grant` has at most one bit set;
  - `en` == |`grant`;
  - `grant` never changes directly from one nonzero value to another.

## Timing
- Grant latency: a request sampled at edge N in IDLE gives `grant`/`en` valid right after edge N (one registered stage).
- Release latency: a `done` or `req` drop sampled at edge N gives `grant` = 0 after edge N.
- Release gap: at least one `en`=0 cycle between consecutive grants, because IDLE is always visited.
- Back-to-back throughput: one grant every (hold cycles + 1) cycles.
- Outputs come straight from registers, with no combinational path from inputs. The downstream encoder therefore sees stable `a`/`en` for a full cycle.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on entry to GRANT and increments on each GRANT cycle.
  - On the edge where the grant has been held `MAX_HOLD` cycles and no normal release is sampled, the release is forced: `grant`=0, `en`=0, `ptr` = winner + 1, state = IDLE.
  - On that same edge `timeout` is set to 1; it returns to 0 on the next edge.
  - If a normal release and the limit coincide, the release is normal and `timeout` stays 0.
- `RR_ARB_TIMEOUT_EN` undefined:
  - No counter is built; `timeout` is tied to 0.
  - A grant may be held indefinitely.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with `req`=4'b1111. Required: `grant`=0, `en`=0, `timeout`=0 throughout. After release, first grant = 4'b0001.
- Single requester: `req`=4'b0100, assert `done` for 1 cycle after 3 grant cycles. Required: `grant`=4'b0100 for exactly 3 cycles, then 0. Next grant with `req`=4'b1111 is 4'b1000 (`ptr`=3).
- Rotation: hold `req`=4'b1111 and pulse `done` one cycle after each grant. Required grant sequence: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 (wrap).
- Owner drop and non-owner noise: while granted to 4'b0010, toggle req[0] and req[3], then drop req[1] with `done`=0. Required: grant stays 0010 until the drop, then 0. Next grant is 4'b0100 if req[2]=1 when IDLE is sampled, else 1000, else 0001.
- Reset mid-grant: assert `rst` while `grant`=4'b1000. Required: `grant`=0 on the next edge, `ptr`=0, next grant with `req`=4'b1001 is 4'b0001.
- Timeout (macro on, `MAX_HOLD`=4): `req`=4'b0001 held, `done`=0. Required: `en`=1 for exactly 4 cycles, then `grant`=0 with `timeout`=1 for one cycle, regrant of 4'b0001 after the IDLE cycle. Macro off: `en` stays 1 and `timeout` stays 0 for 100 cycles.
